// File: rtl/kdtree_stream_loader.sv
// kd-tree stream loader: turns the serial FIFO word stream into node,
// leaf and query table writes (nodes, then leaves, then queries).
//
// Ports:
//   clk, rst             core clock, synchronous active-high reset
//   load_kdtree          one-cycle start pulse (ignored unless idle)
//   in_fifo_*            FWFT FIFO read side (rempty_n, rdata, rdeq)
//   node_w*              internal-node table write (addr, idx, median)
//   leaf_w*              leaf memory write (addr, slot, patch, pidx)
//   query_w*             query buffer write (addr, patch)
//   busy, load_done      load in progress / load completed (level)
module kdtree_stream_loader #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int LEAF_SIZE  = 8,
  parameter int NUM_LEAVES = 64,
  parameter int NUM_QUERYS = 494,
  parameter int IDX_WIDTH  = 3,
  localparam int AW = $clog2(NUM_LEAVES),
  localparam int SW = $clog2(LEAF_SIZE),
  localparam int QW = $clog2(NUM_QUERYS),
  localparam int CW = $clog2(PATCH_SIZE + 1),
  localparam int PW = PATCH_SIZE * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_kdtree,
  input  logic                  in_fifo_rempty_n,
  input  logic [DATA_WIDTH-1:0] in_fifo_rdata,
  output logic                  in_fifo_rdeq,
  output logic                  node_wen,
  output logic [AW-1:0]         node_waddr,
  output logic [IDX_WIDTH-1:0]  node_widx,
  output logic [DATA_WIDTH-1:0] node_wmedian,
  output logic                  leaf_wen,
  output logic [AW-1:0]         leaf_waddr,
  output logic [SW-1:0]         leaf_wslot,
  output logic [PW-1:0]         leaf_wpatch,
  output logic [DATA_WIDTH-1:0] leaf_wpidx,
  output logic                  query_wen,
  output logic [QW-1:0]         query_waddr,
  output logic [PW-1:0]         query_wpatch,
  output logic                  busy,
  output logic                  load_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NODES,
    S_LEAVES,
    S_QUERIES,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST_NODE  = AW'(NUM_LEAVES - 2);
  localparam logic [AW-1:0] LAST_LEAF  = AW'(NUM_LEAVES - 1);
  localparam logic [SW-1:0] LAST_SLOT  = SW'(LEAF_SIZE - 1);
  localparam logic [QW-1:0] LAST_QUERY = QW'(NUM_QUERYS - 1);
  localparam logic [CW-1:0] LAST_COMP  = CW'(PATCH_SIZE - 1);
  localparam logic [CW-1:0] PIDX_COMP  = CW'(PATCH_SIZE);

  state_t                                 state;
  logic [CW-1:0]                          comp;
  logic [AW-1:0]                          node_cnt;
  logic [AW-1:0]                          leaf_cnt;
  logic [SW-1:0]                          slot_cnt;
  logic [QW-1:0]                          query_cnt;
  logic [IDX_WIDTH-1:0]                   idx_q;
  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0]  patch_q;
  logic [PW-1:0]                          query_patch;
  logic                                   take;

  assign in_fifo_rdeq = busy & in_fifo_rempty_n;
  assign take         = in_fifo_rdeq;

  // Query records end on the last component itself, so the written
  // patch merges the head word into the top component slot.
  always_comb begin
    query_patch = patch_q;
    query_patch[PW-1 -: DATA_WIDTH] = in_fifo_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      comp         <= '0;
      node_cnt     <= '0;
      leaf_cnt     <= '0;
      slot_cnt     <= '0;
      query_cnt    <= '0;
      idx_q        <= '0;
      patch_q      <= '0;
      node_wen     <= 1'b0;
      node_waddr   <= '0;
      node_widx    <= '0;
      node_wmedian <= '0;
      leaf_wen     <= 1'b0;
      leaf_waddr   <= '0;
      leaf_wslot   <= '0;
      leaf_wpatch  <= '0;
      leaf_wpidx   <= '0;
      query_wen    <= 1'b0;
      query_waddr  <= '0;
      query_wpatch <= '0;
      busy         <= 1'b0;
      load_done    <= 1'b0;
    end else begin
      node_wen  <= 1'b0;
      leaf_wen  <= 1'b0;
      query_wen <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (load_kdtree) begin
            state     <= S_NODES;
            busy      <= 1'b1;
            load_done <= 1'b0;
            comp      <= '0;
            node_cnt  <= '0;
            leaf_cnt  <= '0;
            slot_cnt  <= '0;
            query_cnt <= '0;
          end
        end
        S_NODES: begin
          if (take) begin
            if (comp == '0) begin
              idx_q <= in_fifo_rdata[IDX_WIDTH-1:0];
              comp  <= CW'(1);
            end else begin
              comp         <= '0;
              node_wen     <= 1'b1;
              node_waddr   <= node_cnt;
              node_widx    <= idx_q;
              node_wmedian <= in_fifo_rdata;
              node_cnt     <= node_cnt + 1'b1;
              if (node_cnt == LAST_NODE) state <= S_LEAVES;
            end
          end
        end
        S_LEAVES: begin
          if (take) begin
            if (comp == PIDX_COMP) begin
              comp        <= '0;
              leaf_wen    <= 1'b1;
              leaf_waddr  <= leaf_cnt;
              leaf_wslot  <= slot_cnt;
              leaf_wpatch <= patch_q;
              leaf_wpidx  <= in_fifo_rdata;
              if (slot_cnt == LAST_SLOT) begin
                slot_cnt <= '0;
                leaf_cnt <= leaf_cnt + 1'b1;
                if (leaf_cnt == LAST_LEAF) state <= S_QUERIES;
              end else begin
                slot_cnt <= slot_cnt + 1'b1;
              end
            end else begin
              patch_q[comp] <= in_fifo_rdata;
              comp          <= comp + 1'b1;
            end
          end
        end
        S_QUERIES: begin
          if (take) begin
            if (comp == LAST_COMP) begin
              comp         <= '0;
              query_wen    <= 1'b1;
              query_waddr  <= query_cnt;
              query_wpatch <= query_patch;
              query_cnt    <= query_cnt + 1'b1;
              if (query_cnt == LAST_QUERY) begin
                state <= S_DONE;
                busy  <= 1'b0;
              end
            end else begin
              patch_q[comp] <= in_fifo_rdata;
              comp          <= comp + 1'b1;
            end
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          load_done <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/kdtree_stream_loader.md
Name: kdtree_stream_loader

Overview:
- Sits directly downstream of the input async FIFO's read side, in the clk domain.
- Consumes the serial 11-bit word stream in a fixed order: internal nodes, then leaves, then query patches.
- Assembles the words into records and emits one-cycle write strobes to the internal-node table, the leaf memory and the query buffer.
- Started by a load_kdtree pulse; signals completion so the top FSM may then accept fsm_start.

Parameters:
- DATA_WIDTH, 11, width of every stream word and patch component
- PATCH_SIZE, 5, components per patch
- LEAF_SIZE, 8, patches per leaf
- NUM_LEAVES, 64, leaves in the kd-tree; internal nodes = NUM_LEAVES-1
- NUM_QUERYS, 494, query patches per frame (26x19)
- IDX_WIDTH, 3, width of the node split-component index ($clog2(PATCH_SIZE))

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- load_kdtree  in  1  one-cycle start pulse
- in_fifo_rempty_n  in  1  FIFO holds a word; rdata valid (first-word-fall-through)
- in_fifo_rdata  in  DATA_WIDTH  head word
- in_fifo_rdeq  out  1  consume head word this cycle
- node_wen  out  1  internal-node write strobe
- node_waddr  out  $clog2(NUM_LEAVES)  node number 0..62
- node_widx  out  IDX_WIDTH  split component index
- node_wmedian  out  DATA_WIDTH  split median
- leaf_wen  out  1  leaf-patch write strobe
- leaf_waddr  out  $clog2(NUM_LEAVES)  leaf number
- leaf_wslot  out  $clog2(LEAF_SIZE)  patch slot in leaf
- leaf_wpatch  out  PATCH_SIZE*DATA_WIDTH  patch, component 0 in LSBs
- leaf_wpidx  out  DATA_WIDTH  patch index in original image
- query_wen  out  1  query write strobe
- query_waddr  out  $clog2(NUM_QUERYS)  query number
- query_wpatch  out  PATCH_SIZE*DATA_WIDTH  query patch, component 0 in LSBs
- busy  out  1  load in progress
- load_done  out  1  level; set on completion, cleared by next load_kdtree or rst

Behaviour:
- Reset (rst high at a clk edge): state IDLE; all counters and assembly registers 0; every output 0.
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- States and transitions:
  - IDLE -> NODES on load_kdtree.
  - NODES -> LEAVES after 2*(NUM_LEAVES-1) words.
  - LEAVES -> QUERIES after NUM_LEAVES*LEAF_SIZE*(PATCH_SIZE+1) words.
  - QUERIES -> DONE after NUM_QUERYS*PATCH_SIZE words.
  - DONE -> IDLE in one cycle; load_done is set on that transition.
- load_kdtree while busy is ignored. load_kdtree in IDLE clears load_done.
- in_fifo_rdeq = busy & in_fifo_rempty_n (combinational). A word is consumed only when both are high. No consumption in IDLE or DONE.
- NODES:
  - Word 0 of each pair is the index; keep its low IDX_WIDTH bits.
  - Word 1 is the median.
  - The cycle after the median is consumed: node_wen=1, node_waddr=pair count, node_widx and node_wmedian registered.
- LEAVES:
  - Each patch is PATCH_SIZE data words followed by 1 image-index word.
  - Data word k is shifted into component k.
  - The cycle after the image-index word: leaf_wen=1 with leaf_waddr, leaf_wslot, leaf_wpatch, leaf_wpidx.
  - leaf_wslot increments 0..7 and wraps to 0; the wrap increments leaf_waddr.
- QUERIES:
  - Every PATCH_SIZE words, query_wen pulses the next cycle with query_waddr = query count.
- Write-data outputs hold their last value between strobes. Strobes are exactly one cycle wide.
- At most one strobe per cycle (one word per cycle guarantees this).
- Latency: the strobe comes 1 cycle after the final word of the record.
- FIFO stalls (rempty_n low) mid-record: assembly state is held and no strobe fires.
- Component counters wrap exactly at PATCH_SIZE-1 and PATCH_SIZE; there are no partial records.
- Upper index bits beyond IDX_WIDTH are ignored. Words are never truncated or sign-extended otherwise.
- rst asserted mid-load: returns to IDLE next edge, with no strobe that cycle. Words already dequeued are lost; upstream must also reset the FIFO.
- busy=1 in NODES, LEAVES and QUERIES only.

Test Plan:
- Reset: hold rst 2 cycles with rempty_n=1 -> all outputs 0, in_fifo_rdeq=0, state IDLE.
- Nodes: pulse load_kdtree, stream index 3 then median 700 (and then 61 further pairs) -> first node_wen with addr 0, idx 3, median 700, one cycle after the 2nd word; 63 node_wen pulses total; last at addr 62.
- Leaves: stream words 1,2,3,4,5,17 for the first patch -> leaf_wen with addr 0, slot 0, patch {5,4,3,2,1}, pidx 17. The 9th patch -> addr 1, slot 0. 512 leaf_wen pulses total.
- Queries with gaps: drop rempty_n for 3 cycles between words 2 and 3 of query 0 -> no strobe during the gap, correct patch assembled. Final query_waddr=493; load_done=1 two cycles after the last word; busy=0.
- Ignored start and restart: pulse load_kdtree during LEAVES -> no effect on counters. After DONE, pulse load_kdtree -> load_done clears and node_waddr restarts at 0.
- Mid-load reset: assert rst during QUERIES at word 100 -> next cycle IDLE, no strobes, in_fifo_rdeq=0, load_done=0.
